// File: rtl/add37_pkg.sv
// Shared constants and result-entry format for the add37 flow-control slice.
// Optional feature macro: ADD37_FLOW_CARRY_EN (adds a carry bit to each result).
package add37_pkg;

    localparam int ADD37_WIDTH   = 37;
    localparam int ADD37_LATENCY = 5;

`ifdef ADD37_FLOW_CARRY_EN
    localparam int ADD37_CARRY_W = 1;

    typedef struct packed {
        logic                   carry;
        logic [ADD37_WIDTH-1:0] sum;
    } add37_entry_t;
`else
    localparam int ADD37_CARRY_W = 0;

    typedef struct packed {
        logic [ADD37_WIDTH-1:0] sum;
    } add37_entry_t;
`endif

    // Carry-out recovered from the operand MSBs and the sum MSB alone.
    function automatic logic add37_carry(input logic xm, input logic ym, input logic sm);
        return (xm & ym) | ((xm ^ ym) & ~sm);
    endfunction

endpackage

// File: rtl/add37_sync_fifo.sv
// Synchronous result FIFO: power-of-2 depth, registered pointers, occupancy count.
// Storage is not reset; only pointers and count are cleared.
module add37_sync_fifo
    import add37_pkg::*;
#(
    parameter int W     = ADD37_WIDTH,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Write the incoming entry at the write pointer.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/add37_flow_ctrl.sv
// Valid/ready wrapper around a fixed-latency, handshake-free pipelined adder.
// Accepted pairs are tagged through a valid pipe matching the adder latency;
// tagged sums land in a result FIFO. Credit (FIFO count + in-flight tags)
// gates in_ready so a tagged sum always has a free slot.
// Optional feature macro: ADD37_FLOW_CARRY_EN (out_carry port, WIDTH+1 entries).
module add37_flow_ctrl
    import add37_pkg::*;
#(
    parameter int WIDTH   = ADD37_WIDTH,
    parameter int LATENCY = ADD37_LATENCY,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum
`ifdef ADD37_FLOW_CARRY_EN
    ,
    output logic             out_carry
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(LATENCY + 1);
    localparam int ENTRY_W = WIDTH + ADD37_CARRY_W;

    logic [LATENCY-1:0] r_vld;
    logic [CW-1:0]      w_inflight;
    logic [AW:0]        w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;

    // The adder sees the operands every cycle; only tagged sums are kept.
    assign add_x = in_x;
    assign add_y = in_y;

    assign w_accept = in_valid & in_ready;
    assign w_push   = r_vld[LATENCY-1];
    assign w_pop    = out_valid & out_ready;

    // Count tags still travelling through the adder.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end

    // Pops in the current cycle are not credited, keeping out_ready off this path.
    assign in_ready = rst_n & ((32'(w_count) + 32'(w_inflight)) < 32'(DEPTH));

    // Valid pipe: a set tag at the last stage marks add_sum as belonging to an accepted pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

`ifdef ADD37_FLOW_CARRY_EN
    logic [LATENCY-1:0] r_xm;
    logic [LATENCY-1:0] r_ym;

    // Operand MSBs follow the tags so the carry can be rebuilt at push time.
    always_ff @(posedge clk) begin
        r_xm[0] <= in_x[WIDTH-1];
        r_ym[0] <= in_y[WIDTH-1];
        for (int i = 1; i < LATENCY; i++) begin
            r_xm[i] <= r_xm[i-1];
            r_ym[i] <= r_ym[i-1];
        end
    end

    assign w_wdata   = {add37_carry(r_xm[LATENCY-1], r_ym[LATENCY-1], add_sum[WIDTH-1]), add_sum};
    assign out_carry = w_rdata[WIDTH];
`else
    assign w_wdata   = add_sum;
`endif

    add37_sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_sum   = w_rdata[WIDTH-1:0];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_add37_flow_ctrl.sv
// Bench for add37_flow_ctrl with a behavioural 5-register adder and a scoreboard.
// Optional feature macro: ADD37_FLOW_CARRY_EN (carry checks enabled).
module tb_add37_flow_ctrl;

    localparam int W       = 37;
    localparam int LATENCY = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic [W-1:0] add_x;
    logic [W-1:0] add_y;
    logic [W-1:0] add_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
`ifdef ADD37_FLOW_CARRY_EN
    logic         out_carry;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int cyc      = 0;

    logic [W:0]   sb_q[$];
    logic [W:0]   sb_exp;
    logic [W-1:0] r_add [LATENCY];

    add37_flow_ctrl #(.WIDTH(W), .LATENCY(LATENCY), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef ADD37_FLOW_CARRY_EN
        ,
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency adder: input register plus four stages, no reset.
    always @(posedge clk) begin
        r_add[0] <= add_x + add_y;
        for (int i = 1; i < LATENCY; i++) r_add[i] <= r_add[i-1];
    end
    assign add_sum = r_add[LATENCY-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: expectations enter on accept, leave on pop; reset discards them.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_sum", 64'(out_sum), 64'(sb_exp[W-1:0]));
`ifdef ADD37_FLOW_CARRY_EN
                    chk("sb_carry", 64'(out_carry), 64'(sb_exp[W]));
`endif
                    n_out++;
                end
            end
            if (in_valid && in_ready) sb_q.push_back({1'b0, in_x} + {1'b0, in_y});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd37();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[W-1:0];
    endfunction

    task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] esum, input logic ecarry);
        int acc_cyc;
        int w;
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
        step();
        acc_cyc = cyc;
        in_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!out_valid && w < 20);
        chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(LATENCY));
        chk({tag, "_sum"}, 64'(out_sum), 64'(esum));
`ifdef ADD37_FLOW_CARRY_EN
        chk({tag, "_carry"}, 64'(out_carry), 64'(ecarry));
`else
        if (ecarry === 1'bx) $display("note: carry not checked");
`endif
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || out_valid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int acc;
        int drops;
        int seen;

        // Reset held with in_valid asserted.
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_x = 37'h123;
        in_y = 37'h456;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_out_valid", 64'(out_valid), 64'(0));
        end
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'(1));
        chk("rel_out_valid", 64'(out_valid), 64'(0));

        // Single operation with latency measurement.
        out_ready = 1'b1;
        step();
        send_one("single", 37'h0_0000_01FF, 37'h0_0000_0001, 37'h0_0000_0200, 1'b0);
        wait_drain("single_drain");

        // Back-to-back random stream.
        n0 = n_out;
        drops = 0;
        step();
        for (int i = 0; i < 100; i++) begin
            in_x = rnd37();
            in_y = rnd37();
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) drops++;
            step();
        end
        in_valid = 1'b0;
        chk("stream_drops", 64'(drops), 64'(0));
        wait_drain("stream_drain");
        chk("stream_count", 64'(n_out - n0), 64'(100));

        // Back-pressure fills exactly DEPTH entries.
        out_ready = 1'b0;
        acc = 0;
        step();
        for (int i = 0; i < 20; i++) begin
            in_x = rnd37();
            in_y = rnd37();
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_accepts", 64'(acc), 64'(8));
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        n0 = n_out;
        step();
        out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_count", 64'(n_out - n0), 64'(8));

        // Reset while three pairs are in flight.
        n0 = n_out;
        step();
        for (int i = 0; i < 3; i++) begin
            in_x = rnd37();
            in_y = rnd37();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rstmid_seen", 64'(seen), 64'(0));
        chk("rstmid_out_valid", 64'(out_valid), 64'(0));
        chk("rstmid_count", 64'(n_out - n0), 64'(0));
        chk("rstmid_in_ready", 64'(in_ready), 64'(1));

        // Carry-boundary operands (sum wraps modulo 2^37).
        step();
        send_one("wrap", 37'h1F_FFFF_FFFF, 37'h0_0000_0001, 37'h0, 1'b1);
        wait_drain("wrap_drain");
        step();
        send_one("nowrap", 37'h0F_FFFF_FFFF, 37'h0F_FFFF_FFFF, 37'h1F_FFFF_FFFE, 1'b0);
        wait_drain("nowrap_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
